// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a stalling instruction memory,
// and hands instructions (or NOP bubbles) to the IF/ID register.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_done,
  output logic [15:0] instr_f,
  output logic [15:0] pc_f,
  output logic        fetch_valid,
  output logic        halted,
  output logic        err
);

  localparam int unsigned W = 16;
  localparam logic [W-1:0] PC_STEP = W'(2);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t       state, state_n;
  logic [W-1:0] pc, pc_n;
  logic [W-1:0] buffer, buffer_n;
  logic         pend, pend_n;
  logic [W-1:0] target, target_n;

  logic         accept;
  logic         is_halt;

  // State and datapath registers; halted mirrors the registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      buffer <= NOP_INSTR;
      pend   <= 1'b0;
      target <= RESET_PC;
      err    <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      buffer <= buffer_n;
      pend   <= pend_n;
      target <= target_n;
      err    <= err | (redirect & redirect_pc[0]);
      halted <= (state_n == HALT);
    end
  end

  // Next-state and datapath update; redirect outranks everything else.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    buffer_n = buffer;
    pend_n   = pend;
    target_n = target;

    unique case (state)
      FETCH, WAIT: begin
        if (redirect) begin
          if (imem_done) begin
            pc_n     = redirect_pc;
            pend_n   = 1'b0;
            buffer_n = NOP_INSTR;
            state_n  = FETCH;
          end else begin
            pend_n   = 1'b1;
            target_n = redirect_pc;
            state_n  = WAIT;
          end
        end else if (!imem_done) begin
          state_n = WAIT;
        end else if ((state == WAIT) && pend) begin
          // Data from the abandoned path is dropped.
          pc_n    = target;
          pend_n  = 1'b0;
          state_n = FETCH;
        end else if (stall) begin
          buffer_n = imem_rdata;
          state_n  = HOLD;
        end else if (is_halt) begin
          state_n = HALT;
        end else begin
          pc_n    = pc + PC_STEP;
          state_n = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_n     = redirect_pc;
          buffer_n = NOP_INSTR;
          state_n  = FETCH;
        end else if (accept) begin
          state_n = is_halt ? HALT : FETCH;
          if (!is_halt) pc_n = pc + PC_STEP;
        end
      end
      HALT: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  // Memory request and delivery to IF/ID; a hit is forwarded in the same cycle.
  always_comb begin
    imem_rd     = 1'b0;
    instr_f     = NOP_INSTR;
    fetch_valid = 1'b0;

    unique case (state)
      FETCH: begin
        imem_rd = 1'b1;
        if (imem_done && !redirect) begin
          instr_f     = imem_rdata;
          fetch_valid = 1'b1;
        end
      end
      WAIT: begin
        imem_rd = 1'b1;
        if (imem_done && !redirect && !pend) begin
          instr_f     = imem_rdata;
          fetch_valid = 1'b1;
        end
      end
      HOLD: begin
        if (!redirect) begin
          instr_f     = buffer;
          fetch_valid = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign accept    = fetch_valid & ~stall;
  assign is_halt   = (instr_f[15:11] == 5'b00000);
  assign imem_addr = pc;
  assign pc_f      = pc + PC_STEP;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle vector table plus hand-written
// sequences for HOLD/HALT/redirect interactions.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_done;
  logic [15:0] instr_f;
  logic [15:0] pc_f;
  logic        fetch_valid;
  logic        halted;
  logic        err;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_done   (imem_done),
    .instr_f     (instr_f),
    .pc_f        (pc_f),
    .fetch_valid (fetch_valid),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic [15:0] rdata;
    logic        done;
    logic        chk;
    logic        e_rd;
    logic [15:0] e_addr;
    logic [15:0] e_instr;
    logic [15:0] e_pcf;
    logic        e_valid;
    logic        e_halted;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge; return at the falling edge.
  task automatic step(input logic r, input logic s, input logic rd_in,
                      input logic [15:0] rpc, input logic [15:0] data, input logic dn);
    @(posedge clk);
    #1;
    rst = r; stall = s; redirect = rd_in; redirect_pc = rpc;
    imem_rdata = data; imem_done = dn;
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic e_rd, input logic [15:0] e_addr,
                         input logic [15:0] e_instr, input logic [15:0] e_pcf,
                         input logic e_valid, input logic e_halted, input logic e_err);
    chk({tag, ".imem_rd"},     16'(imem_rd),     16'(e_rd));
    chk({tag, ".imem_addr"},   imem_addr,        e_addr);
    chk({tag, ".instr_f"},     instr_f,          e_instr);
    chk({tag, ".pc_f"},        pc_f,             e_pcf);
    chk({tag, ".fetch_valid"}, 16'(fetch_valid), 16'(e_valid));
    chk({tag, ".halted"},      16'(halted),      16'(e_halted));
    chk({tag, ".err"},         16'(err),         16'(e_err));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rdata = '0; imem_done = 1'b0;

    //            rst stl rdr rpc       rdata     dn chk rd addr      instr     pc_f      v  h  e
    vecs.push_back('{1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 16'h1234, 1, 1, 1, 16'h0000, 16'h1234, 16'h0002, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 16'h5678, 1, 1, 1, 16'h0002, 16'h5678, 16'h0004, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h0004, 16'h0800, 16'h0006, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h0004, 16'h0800, 16'h0006, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h0004, 16'h0800, 16'h0006, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 16'h9abc, 1, 1, 1, 16'h0004, 16'h9abc, 16'h0006, 1, 0, 0});
    vecs.push_back('{0, 1, 0, 16'h0000, 16'h1111, 1, 1, 1, 16'h0006, 16'h1111, 16'h0008, 1, 0, 0});
    vecs.push_back('{0, 1, 0, 16'h0000, 16'hdead, 0, 1, 0, 16'h0006, 16'h1111, 16'h0008, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 16'hdead, 0, 1, 0, 16'h0006, 16'h1111, 16'h0008, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h0008, 16'h0800, 16'h000a, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 16'h0040, 16'h0000, 0, 1, 1, 16'h0008, 16'h0800, 16'h000a, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 16'h2222, 1, 1, 1, 16'h0008, 16'h0800, 16'h000a, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 16'h3333, 1, 1, 1, 16'h0040, 16'h3333, 16'h0042, 1, 0, 0});
    vecs.push_back('{0, 0, 1, 16'h0010, 16'h4444, 1, 1, 1, 16'h0042, 16'h0800, 16'h0044, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 16'h0000, 1, 1, 1, 16'h0010, 16'h0000, 16'h0012, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0010, 16'h0800, 16'h0012, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 16'h5555, 1, 1, 0, 16'h0010, 16'h0800, 16'h0012, 0, 1, 0});
    vecs.push_back('{0, 0, 1, 16'h0020, 16'h0000, 0, 1, 0, 16'h0010, 16'h0800, 16'h0012, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 16'h6666, 1, 1, 1, 16'h0020, 16'h6666, 16'h0022, 1, 0, 0});
    vecs.push_back('{0, 0, 1, 16'h0031, 16'h7777, 1, 1, 1, 16'h0022, 16'h0800, 16'h0024, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 16'h8888, 1, 1, 1, 16'h0031, 16'h8888, 16'h0033, 1, 0, 1});
    vecs.push_back('{0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h0033, 16'h0800, 16'h0035, 0, 0, 1});
    vecs.push_back('{1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 16'h1357, 1, 1, 1, 16'h0000, 16'h1357, 16'h0002, 1, 0, 0});
    vecs.push_back('{0, 0, 1, 16'hfffe, 16'h0000, 1, 1, 1, 16'h0002, 16'h0800, 16'h0004, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 16'h2468, 1, 1, 1, 16'hfffe, 16'h2468, 16'h0000, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 16'h0000, 16'h0abc, 1, 1, 1, 16'h0000, 16'h0abc, 16'h0002, 1, 0, 0});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].rdata, vecs[i].done);
      if (vecs[i].chk)
        chk_all($sformatf("v%0d", i), vecs[i].e_rd, vecs[i].e_addr, vecs[i].e_instr,
                vecs[i].e_pcf, vecs[i].e_valid, vecs[i].e_halted, vecs[i].e_err);
    end

    // HALT parked in HOLD is not accepted; redirect with stall wins, then stall is honoured.
    step(1, 0, 0, 16'h0000, 16'h0000, 0);
    step(0, 1, 0, 16'h0000, 16'h0000, 1);
    chk_all("hold_halt0", 1, 16'h0000, 16'h0000, 16'h0002, 1, 0, 0);
    step(0, 1, 0, 16'h0000, 16'hffff, 0);
    chk_all("hold_halt1", 0, 16'h0000, 16'h0000, 16'h0002, 1, 0, 0);
    step(0, 1, 1, 16'h0100, 16'h0000, 0);
    chk_all("stall_redir", 0, 16'h0000, 16'h0800, 16'h0002, 0, 0, 0);
    step(0, 1, 0, 16'h0000, 16'habcd, 1);
    chk_all("post_redir_stall", 1, 16'h0100, 16'habcd, 16'h0102, 1, 0, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0);
    chk_all("post_redir_accept", 0, 16'h0100, 16'habcd, 16'h0102, 1, 0, 0);

    // Newer redirect while one is pending overwrites the target.
    step(0, 0, 0, 16'h0000, 16'h0000, 0);
    chk_all("miss102", 1, 16'h0102, 16'h0800, 16'h0104, 0, 0, 0);
    step(0, 0, 1, 16'h0200, 16'h0000, 0);
    step(0, 0, 1, 16'h0300, 16'h0000, 0);
    chk_all("redir_overwrite", 1, 16'h0102, 16'h0800, 16'h0104, 0, 0, 0);
    step(0, 0, 0, 16'h0000, 16'h1111, 1);
    chk_all("pend_discard", 1, 16'h0102, 16'h0800, 16'h0104, 0, 0, 0);
    step(0, 0, 0, 16'h0000, 16'h2222, 1);
    chk_all("pend_target", 1, 16'h0300, 16'h2222, 16'h0302, 1, 0, 0);

    // HALT accepted out of HOLD when stall falls; PC stays on the HALT.
    step(0, 1, 0, 16'h0000, 16'h07ff, 1);
    chk_all("halt_hold", 1, 16'h0302, 16'h07ff, 16'h0304, 1, 0, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0);
    chk_all("halt_accept", 0, 16'h0302, 16'h07ff, 16'h0304, 1, 0, 0);
    step(0, 0, 0, 16'h0000, 16'h4321, 1);
    chk_all("halt_state", 0, 16'h0302, 16'h0800, 16'h0304, 0, 1, 0);

    // Misaligned redirect out of HALT sets err; reset during WAIT clears everything.
    step(0, 0, 1, 16'h0501, 16'h0000, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0);
    chk_all("halt_err_wait", 1, 16'h0501, 16'h0800, 16'h0503, 0, 0, 1);
    step(1, 0, 0, 16'h0000, 16'h0000, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 0);
    chk_all("rst_from_wait", 1, 16'h0000, 16'h0800, 16'h0002, 0, 0, 0);
    step(0, 0, 0, 16'h0000, 16'h3c3c, 1);
    chk_all("rst_wait_done", 1, 16'h0000, 16'h3c3c, 16'h0002, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage 16-bit pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC register and drives a stalling instruction memory (Done/Stall-style handshake).
- Presents instr_f and pc_f (PC+2 of the delivered instruction) to IF/ID.
- Inserts NOP bubbles on misses and redirects; handles downstream stall, branch/jump redirect and HALT.

Parameters:
- RESET_PC, 16'h0000, PC value after reset.
- NOP_INSTR, 16'h0800, encoding driven on instr_f when no valid instruction is delivered.

Ports:
- clk  input  1  clock (all state on rising edge)
- rst  input  1  reset; synchronous, active-high
- stall  input  1  hazard unit: IF/ID is holding; do not advance
- redirect  input  1  taken branch/jump from a later stage
- redirect_pc  input  16  target PC for redirect
- imem_rd  output  1  instruction memory read request
- imem_addr  output  16  read address (always equals current PC)
- imem_rdata  input  16  read data, valid when imem_done=1
- imem_done  input  1  access complete this cycle (same-cycle = hit)
- instr_f  output  16  instruction to IF/ID (NOP_INSTR when fetch_valid=0)
- pc_f  output  16  PC+2 of the delivered instruction
- fetch_valid  output  1  instr_f carries a real instruction
- halted  output  1  fetch has stopped on HALT
- err  output  1  sticky: misaligned redirect target

Behaviour:
- Reset, synchronous: PC=RESET_PC, state=FETCH, buffer=NOP_INSTR, pending_redirect=0, err=0, halted=0.
  - Outputs after the reset edge: fetch_valid=0, imem_rd=1, imem_addr=RESET_PC.
  - Reset mid-operation (any state, including WAIT) abandons everything; the memory is reset alongside.
- pc_f is always PC+2, modulo 2^16: PC 0xFFFE gives pc_f 0x0000 and wraps.
- "Accept" means the instruction is delivered with fetch_valid=1 and stall=0 in the same cycle.
- States:
  - FETCH:
    - imem_rd=1.
    - imem_done=1: instr_f=imem_rdata, fetch_valid=1 (zero-latency hit).
      - stall=0: PC<=PC+2, stay in FETCH.
      - stall=1: buffer<=imem_rdata, go to HOLD.
    - imem_done=0: fetch_valid=0, go to WAIT.
  - WAIT:
    - imem_rd=1; imem_addr held stable until imem_done.
    - fetch_valid=0 every cycle until done.
    - On imem_done, behave exactly as FETCH with imem_done=1.
  - HOLD:
    - imem_rd=0; instr_f=buffer, fetch_valid=1, stable every cycle.
    - stall falls: accept, PC<=PC+2, go to FETCH.
  - HALT:
    - imem_rd=0, fetch_valid=0, halted=1, PC frozen.
    - Exits only on redirect or reset.
- HALT detection: an accepted instruction with [15:11]==5'b00000 leaves PC unchanged (pc_f already shows PC+2) and moves to HALT next cycle.
  - A HALT sitting in HOLD is not yet accepted.
- Redirect, highest priority (outranks stall, hit delivery and HALT):
  - In FETCH, HOLD or HALT:
    - fetch_valid=0 that cycle.
    - Buffer discarded, PC<=redirect_pc, halted<=0, go to FETCH.
  - In WAIT, or FETCH with a miss:
    - Latch pending_redirect and the target; stay in/enter WAIT; fetch_valid=0.
    - When imem_done arrives, discard the data, set PC<=target, go to FETCH.
    - A newer redirect while pending overwrites the target.
- redirect_pc[0]=1: err<=1 (sticky until reset); the redirect is still taken.
- Simultaneous stall=1 and redirect=1: redirect wins; the subsequent FETCH honours stall.

Test Plan:
- Reset, then hit on every access, imem_rdata=0x1234/0x5678 -> pc_f 0x0002,0x0004; fetch_valid=1 each cycle; imem_addr 0x0000,0x0002.
- Miss at PC 0x0004 with 3-cycle latency -> 3 NOP cycles (instr_f=0x0800, fetch_valid=0), then delivery with pc_f=0x0006; imem_addr stays 0x0004 throughout.
- Hit with stall high for 2 cycles -> instr_f held stable, imem_rd=0 in HOLD, PC advances only on the cycle stall falls.
- Redirect to 0x0040 during WAIT -> returned data discarded, next access at 0x0040, no valid instruction from the old path.
- Fetch 0x0000 (HALT) at PC 0x0010 -> halted=1, imem_rd=0, PC frozen at 0x0010; redirect to 0x0020 -> halted=0, fetch resumes at 0x0020.
- Redirect to 0x0031 -> err=1 and stays set; PC=0x0031; a following reset clears err. Separately, PC 0xFFFE hit -> pc_f=0x0000.
